// File: rtl/lock_sequence_ctrl.sv
// lock_sequence_ctrl
// Single-clock sequencing controller for the button-driven combination lock.
// Converts rising edges of the ZERO/ONE/RESET button levels into code digits
// and compares a full attempt against CODE (first digit = MSB). On a match it
// drives a timed unlock window.
//
// Optional feature macro: LOCK_SEQ_LOCKOUT_EN
//   defined   : consecutive failed attempts are counted and MAX_FAILS of them
//               trigger a LOCKOUT period of LOCKOUT_CYCLES cycles.
//   undefined : fail_cnt and locked_out are tied low, no LOCKOUT state exists,
//               and a mismatch simply returns to digit entry.
//
// Reset: clr_bar, synchronous, active-low. Every register, including the
// button edge history, clears, so a button held through reset release is
// seen as a fresh press on the first cycle afterwards.
module lock_sequence_ctrl #(
  parameter int                  CODE_LEN       = 4,
  parameter logic [CODE_LEN-1:0] CODE           = 4'b1011,
  parameter int                  UNLOCK_CYCLES  = 8,
  parameter int                  MAX_FAILS      = 3,
  parameter int                  LOCKOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       clr_bar,
  input  logic       zero_btn,
  input  logic       one_btn,
  input  logic       reset_btn,
  output logic       unlock,
  output logic       locked_out,
  output logic [3:0] digit_cnt,
  output logic [2:0] fail_cnt,
  output logic       digit_strobe
);

  // The shared timer only ever holds (duration - 1), so it needs enough
  // bits to represent the larger of the two durations minus one.
  localparam int TMR_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES
                                                            : LOCKOUT_CYCLES;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  localparam logic [3:0]       LAST_DIGIT  = 4'(CODE_LEN);
  localparam logic [TMR_W-1:0] UNLOCK_LOAD = TMR_W'(UNLOCK_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_ONE     = TMR_W'(1);

  localparam logic [1:0] ST_ENTRY    = 2'd0;
  localparam logic [1:0] ST_CHECK    = 2'd1;
  localparam logic [1:0] ST_UNLOCKED = 2'd2;
`ifdef LOCK_SEQ_LOCKOUT_EN
  localparam logic [1:0] ST_LOCKOUT  = 2'd3;

  localparam logic [TMR_W-1:0] LOCKOUT_LOAD = TMR_W'(LOCKOUT_CYCLES - 1);
  localparam logic [2:0]       FAIL_LIMIT   = 3'(MAX_FAILS);

  // Saturating increment of the consecutive-failure count.
  function automatic logic [2:0] fail_sat_inc(input logic [2:0] cur);
    if (cur >= FAIL_LIMIT) begin
      return FAIL_LIMIT;
    end
    return cur + 3'd1;
  endfunction
`endif

  // Button edge history and derived single-cycle press pulses.
  logic zero_q;
  logic one_q;
  logic reset_btn_q;
  logic zero_press;
  logic one_press;
  logic reset_press;
  logic digit_press;

  // Controller state and the values it will take at the next edge.
  logic [1:0]          state_q;
  logic [1:0]          state_nxt;
  logic [CODE_LEN-1:0] shift_q;
  logic [CODE_LEN-1:0] shift_nxt;
  logic [3:0]          cnt_nxt;
  logic [TMR_W-1:0]    timer_q;
  logic [TMR_W-1:0]    timer_nxt;
  logic                strobe_nxt;
`ifdef LOCK_SEQ_LOCKOUT_EN
  logic [2:0]          fail_nxt;
`endif

  assign zero_press  = zero_btn  & ~zero_q;
  assign one_press   = one_btn   & ~one_q;
  assign reset_press = reset_btn & ~reset_btn_q;
  // Both digit buttons rising together is ambiguous and is discarded.
  assign digit_press = zero_press ^ one_press;

  // Edge history updates in every state so a held button never re-triggers.
  always_ff @(posedge clk) begin
    if (!clr_bar) begin
      zero_q      <= 1'b0;
      one_q       <= 1'b0;
      reset_btn_q <= 1'b0;
    end else begin
      zero_q      <= zero_btn;
      one_q       <= one_btn;
      reset_btn_q <= reset_btn;
    end
  end

  // Next-state logic: digit entry, attempt check, unlock and lockout timing.
  always_comb begin
    state_nxt  = state_q;
    shift_nxt  = shift_q;
    cnt_nxt    = digit_cnt;
    timer_nxt  = timer_q;
    strobe_nxt = 1'b0;
`ifdef LOCK_SEQ_LOCKOUT_EN
    fail_nxt   = fail_cnt;
`endif

    case (state_q)
      ST_ENTRY: begin
        if (reset_press) begin
          // Abandoning the attempt wins over a digit in the same cycle.
          shift_nxt = '0;
          cnt_nxt   = 4'd0;
        end else if (digit_press) begin
          // Shift left so the first digit ends up in the MSB; the cast
          // drops the oldest bit and also covers CODE_LEN == 1.
          shift_nxt  = CODE_LEN'({shift_q, one_press});
          cnt_nxt    = digit_cnt + 4'd1;
          strobe_nxt = 1'b1;
          if (cnt_nxt == LAST_DIGIT) begin
            state_nxt = ST_CHECK;
          end
        end
      end

      ST_CHECK: begin
        // One-cycle evaluation; presses are ignored and the attempt clears.
        shift_nxt = '0;
        cnt_nxt   = 4'd0;
        if (shift_q == CODE) begin
          timer_nxt = UNLOCK_LOAD;
          state_nxt = ST_UNLOCKED;
`ifdef LOCK_SEQ_LOCKOUT_EN
          fail_nxt  = 3'd0;
`endif
        end else begin
`ifdef LOCK_SEQ_LOCKOUT_EN
          fail_nxt = fail_sat_inc(fail_cnt);
          if (fail_nxt == FAIL_LIMIT) begin
            timer_nxt = LOCKOUT_LOAD;
            state_nxt = ST_LOCKOUT;
          end else begin
            state_nxt = ST_ENTRY;
          end
`else
          state_nxt = ST_ENTRY;
`endif
        end
      end

      ST_UNLOCKED: begin
        // A RESET press relocks at once; otherwise run out the timer.
        if (reset_press || (timer_q == '0)) begin
          state_nxt = ST_ENTRY;
        end else begin
          timer_nxt = timer_q - TMR_ONE;
        end
      end

`ifdef LOCK_SEQ_LOCKOUT_EN
      ST_LOCKOUT: begin
        // Every button, RESET included, is ignored until the timer expires.
        if (timer_q == '0) begin
          fail_nxt  = 3'd0;
          state_nxt = ST_ENTRY;
        end else begin
          timer_nxt = timer_q - TMR_ONE;
        end
      end
`endif

      default: begin
        state_nxt = ST_ENTRY;
      end
    endcase
  end

  // Main control registers; outputs are registered from next-state values.
  always_ff @(posedge clk) begin
    if (!clr_bar) begin
      state_q      <= ST_ENTRY;
      shift_q      <= '0;
      digit_cnt    <= 4'd0;
      timer_q      <= '0;
      digit_strobe <= 1'b0;
      unlock       <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      shift_q      <= shift_nxt;
      digit_cnt    <= cnt_nxt;
      timer_q      <= timer_nxt;
      digit_strobe <= strobe_nxt;
      unlock       <= (state_nxt == ST_UNLOCKED);
    end
  end

`ifdef LOCK_SEQ_LOCKOUT_EN
  // Failure counter and lockout indicator.
  always_ff @(posedge clk) begin
    if (!clr_bar) begin
      fail_cnt   <= 3'd0;
      locked_out <= 1'b0;
    end else begin
      fail_cnt   <= fail_nxt;
      locked_out <= (state_nxt == ST_LOCKOUT);
    end
  end
`else
  assign fail_cnt   = 3'd0;
  assign locked_out = 1'b0;
`endif

endmodule
